uart_rx_cmd_decoder: RTL and testbench

Command-frame decoder sitting directly downstream of the UART receiver in the system controller path. It consumes the receiver's parallel bytes (`P_DATA` / `data_valid`) and its error flags. It assembles multi-byte command frames and issues single-cycle register-file write/read strobes and ALU launch strobes. Malformed, erroneous or unknown frames are discarded and flagged.

---
 rtl/uart_cmd_pkg.sv | 32 +++
 rtl/uart_rx_cmd_decoder_timeout.sv | 29 ++
 rtl/uart_rx_cmd_decoder.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_cmd_decoder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame decoder.
// Holds the FSM state enum, command bytes and ALU operand addresses.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN
    } cmd_state_e;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned ALU_A_ADDR = 0;
    localparam int unsigned ALU_B_ADDR = 1;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_RF_WR) || (b == CMD_RF_RD) ||
               (b == CMD_ALU_OP) || (b == CMD_ALU_NOP);
    endfunction

    function automatic logic fun_ok(input logic [7:0] b);
        return b[7:4] == 4'h0;
    endfunction

endpackage

// File: rtl/uart_rx_cmd_decoder_timeout.sv
// Mid-frame idle counter for the command decoder (RX_CMD_TIMEOUT_EN builds).
// Expires after LIMIT consecutive byte-free cycles while a frame is open.
module cmd_timeout_counter #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt;

    assign expired = active && !clear && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !active || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Command-frame decoder behind the UART receiver: frames -> RF/ALU strobes.
// Optional mid-frame idle abort is enabled by defining RX_CMD_TIMEOUT_EN.
module uart_rx_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_p_data,
    input  logic                  rx_data_valid,
    input  logic                  rx_par_err,
    input  logic                  rx_frm_err,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [7:0]            rf_wr_data,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [3:0]            alu_fun,
    output logic                  alu_en,
    output logic                  cmd_err,
    output logic                  busy
);

    cmd_state_e state, state_d;

    logic                  err_any, err_q, err_rise;
    logic                  take, abort, timeout;
    logic                  addr_ok;
    logic [ADDR_WIDTH-1:0] byte_addr;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, rf_addr_d;
    logic [7:0]            data_d;
    logic [3:0]            fun_d;
    logic                  wr_d, rd_d, alu_d, err_d;

    assign err_any   = rx_par_err | rx_frm_err;
    assign err_rise  = err_any && !err_q;
    assign abort     = err_any && (state != ST_IDLE);
    assign take      = rx_data_valid && !err_any;
    assign addr_ok   = (rx_p_data >> ADDR_WIDTH) == 8'h00;
    assign byte_addr = rx_p_data[ADDR_WIDTH-1:0];
    assign busy      = (state != ST_IDLE);

`ifdef RX_CMD_TIMEOUT_EN
    cmd_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_data_valid),
        .active  (state != ST_IDLE),
        .expired (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 2);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            err_q <= err_any;
        end
    end

    always_comb begin
        state_d = state;
        if (abort || timeout) begin
            state_d = ST_IDLE;
        end else if (take) begin
            unique case (state)
                ST_IDLE: begin
                    unique case (1'b1)
                        (rx_p_data == CMD_RF_WR):   state_d = ST_WR_ADDR;
                        (rx_p_data == CMD_RF_RD):   state_d = ST_RD_ADDR;
                        (rx_p_data == CMD_ALU_OP):  state_d = ST_ALU_A;
                        (rx_p_data == CMD_ALU_NOP): state_d = ST_ALU_FUN;
                        default:                    state_d = ST_IDLE;
                    endcase
                end
                ST_WR_ADDR: state_d = addr_ok ? ST_WR_DATA : ST_IDLE;
                ST_ALU_A:   state_d = ST_ALU_B;
                ST_ALU_B:   state_d = ST_ALU_FUN;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; held fields keep their value.
    always_comb begin
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        alu_d     = 1'b0;
        err_d     = 1'b0;
        addr_d    = addr_q;
        rf_addr_d = rf_addr;
        data_d    = rf_wr_data;
        fun_d     = alu_fun;
        if (abort || timeout) begin
            err_d = 1'b1;
        end else if ((state == ST_IDLE) && err_rise) begin
            err_d = 1'b1;
        end else if (take) begin
            unique case (state)
                ST_IDLE: err_d = !is_cmd(rx_p_data);
                ST_WR_ADDR: begin
                    if (addr_ok) addr_d = byte_addr;
                    else         err_d  = 1'b1;
                end
                ST_WR_DATA: begin
                    wr_d      = 1'b1;
                    rf_addr_d = addr_q;
                    data_d    = rx_p_data;
                end
                ST_RD_ADDR: begin
                    if (addr_ok) begin
                        rd_d      = 1'b1;
                        rf_addr_d = byte_addr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_ALU_A: begin
                    wr_d      = 1'b1;
                    rf_addr_d = ADDR_WIDTH'(ALU_A_ADDR);
                    data_d    = rx_p_data;
                end
                ST_ALU_B: begin
                    wr_d      = 1'b1;
                    rf_addr_d = ADDR_WIDTH'(ALU_B_ADDR);
                    data_d    = rx_p_data;
                end
                ST_ALU_FUN: begin
                    if (fun_ok(rx_p_data)) begin
                        alu_d = 1'b1;
                        fun_d = rx_p_data[3:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            rf_addr    <= '0;
            rf_wr_data <= 8'h00;
            alu_fun    <= 4'h0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rf_addr    <= rf_addr_d;
            rf_wr_data <= data_d;
            alu_fun    <= fun_d;
            rf_wr_en   <= wr_d;
            rf_rd_en   <= rd_d;
            alu_en     <= alu_d;
            cmd_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: frame-level model plus directed pins.
// Covers the RX_CMD_TIMEOUT_EN build when that macro is defined.
module tb_uart_rx_cmd_decoder;

    localparam int AW  = 4;
    localparam int TOC = 16;
`ifdef RX_CMD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_p_data = 8'h00;
    logic          rx_data_valid = 1'b0;
    logic          rx_par_err = 1'b0;
    logic          rx_frm_err = 1'b0;
    logic [AW-1:0] rf_addr;
    logic [7:0]    rf_wr_data;
    logic          rf_wr_en, rf_rd_en, alu_en, cmd_err, busy;
    logic [3:0]    alu_fun;

    always #5 clk = ~clk;

    uart_rx_cmd_decoder #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_p_data     (rx_p_data),
        .rx_data_valid (rx_data_valid),
        .rx_par_err    (rx_par_err),
        .rx_frm_err    (rx_frm_err),
        .rf_addr       (rf_addr),
        .rf_wr_data    (rf_wr_data),
        .rf_wr_en      (rf_wr_en),
        .rf_rd_en      (rf_rd_en),
        .alu_fun       (alu_fun),
        .alu_en        (alu_en),
        .cmd_err       (cmd_err),
        .busy          (busy)
    );

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame-level model: collects the bytes of the open frame in a queue
    byte unsigned  frame[$];
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    logic [3:0]    m_fun;
    logic          m_wr, m_rd, m_alu, m_err, m_err_prev;
    int            cyc, last_cyc;

    task automatic m_fail();
        m_err = 1'b1;
        frame.delete();
    endtask

    task automatic m_write(input int a, input byte unsigned d);
        m_wr   = 1'b1;
        m_addr = AW'(a);
        m_data = d;
    endtask

    task automatic model_byte(input byte unsigned b);
        int n;
        frame.push_back(b);
        n = frame.size();
        if (n == 1) begin
            if (!(b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})) m_fail();
        end else begin
            case (frame[0])
                8'hAA: begin
                    if (n == 2 && b >= (1 << AW)) m_fail();
                    else if (n == 3) begin
                        m_write(int'(frame[1]), b);
                        frame.delete();
                    end
                end
                8'hBB: begin
                    if (b >= (1 << AW)) m_fail();
                    else begin
                        m_rd   = 1'b1;
                        m_addr = AW'(b);
                        frame.delete();
                    end
                end
                8'hCC: begin
                    if (n == 2) m_write(0, b);
                    else if (n == 3) m_write(1, b);
                    else if (b > 15) m_fail();
                    else begin
                        m_alu = 1'b1;
                        m_fun = 4'(b);
                        frame.delete();
                    end
                end
                default: begin
                    if (b > 15) m_fail();
                    else begin
                        m_alu = 1'b1;
                        m_fun = 4'(b);
                        frame.delete();
                    end
                end
            endcase
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame.delete();
            m_addr = '0;
            m_data = 8'h00;
            m_fun = 4'h0;
            {m_wr, m_rd, m_alu, m_err, m_err_prev} = 5'b0;
        end else begin
            logic e;
            e = rx_par_err | rx_frm_err;
            {m_wr, m_rd, m_alu, m_err} = 4'b0;
            cyc++;
            if (e) begin
                if (frame.size() != 0) m_fail();
                else if (!m_err_prev) m_err = 1'b1;
            end else if (rx_data_valid) begin
                model_byte(rx_p_data);
            end else if (TO_EN && frame.size() != 0 && cyc - last_cyc == TOC) begin
                m_fail();
            end
            if (rx_data_valid) last_cyc = cyc;
            m_err_prev = e;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs",
                  {11'b0, rf_addr, rf_wr_data, alu_fun,
                   rf_wr_en, rf_rd_en, alu_en, cmd_err, busy},
                  {11'b0, m_addr, m_data, m_fun,
                   m_wr, m_rd, m_alu, m_err, frame.size() != 0});
            check("one_strobe", 32'(rf_wr_en + rf_rd_en + alu_en <= 1), 32'd1);
        end
    end

    // Strobe logs for the directed literal expectations
    int wr_q[$];
    int rd_q[$];
    int alu_q[$];
    int err_cnt;

    always @(negedge clk) begin
        if (rf_wr_en) wr_q.push_back({rf_addr, rf_wr_data});
        if (rf_rd_en) rd_q.push_back(int'(rf_addr));
        if (alu_en)   alu_q.push_back(int'(alu_fun));
        if (cmd_err)  err_cnt++;
    end

    task automatic clr_logs();
        wr_q.delete();
        rd_q.delete();
        alu_q.delete();
        err_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic put(input byte unsigned b);
        rx_p_data = b;
        rx_data_valid = 1'b1;
        step();
    endtask

    task automatic gap(input int n);
        rx_data_valid = 1'b0;
        repeat (n) step();
    endtask

    function automatic byte unsigned rnd_byte();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) begin
            case ($urandom_range(0, 3))
                0: return 8'hAA;
                1: return 8'hBB;
                2: return 8'hCC;
                default: return 8'hDD;
            endcase
        end
        if (r < 7) return 8'($urandom_range(0, 19));
        return 8'($urandom);
    endfunction

    initial begin
        int  e_left;
        bit  esel;
        e_left = 0;
        esel = 1'b0;
        step();
        check("reset_outputs",
              {rf_addr, rf_wr_data, alu_fun, rf_wr_en, rf_rd_en,
               alu_en, cmd_err, busy}, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        clr_logs();
        put(8'hAA); put(8'h05); put(8'h3C); gap(3);
        check("wr_count", wr_q.size(), 1);
        check("wr_5_3c", wr_q[0], 32'h53C);
        check("wr_no_err", err_cnt, 0);

        clr_logs();
        put(8'hBB); put(8'h0F); gap(3);
        check("rd_count", rd_q.size(), 1);
        check("rd_addr_f", rd_q[0], 32'hF);

        clr_logs();
        put(8'hCC); put(8'h12); put(8'h34); put(8'h02); gap(3);
        check("alu_wr_count", wr_q.size(), 2);
        check("alu_wr_a", wr_q[0], 32'h012);
        check("alu_wr_b", wr_q[1], 32'h134);
        check("alu_fun_2", alu_q.size() == 1 ? alu_q[0] : -1, 2);

        clr_logs();
        put(8'hDD); put(8'h0A); put(8'hAA); put(8'h01); put(8'hFF); gap(3);
        check("b2b_alu_a", alu_q.size() == 1 ? alu_q[0] : -1, 32'hA);
        check("b2b_wr", wr_q.size() == 1 ? wr_q[0] : -1, 32'h1FF);

        clr_logs();
        put(8'hAA); gap(1);
        rx_frm_err = 1'b1; step();
        rx_frm_err = 1'b0; gap(1);
        check("abort_err", err_cnt, 1);
        check("abort_idle", busy, 0);
        put(8'h07); put(8'h55); gap(3);
        check("abort_unknown_err", err_cnt, 3);
        check("abort_no_wr", wr_q.size(), 0);

        clr_logs();
        put(8'hAA); put(8'h10); put(8'hFF); gap(1);
        put(8'hDD); put(8'h1F); gap(3);
        check("range_err", err_cnt, 3);
        check("range_no_strobe", wr_q.size() + alu_q.size(), 0);

        clr_logs();
        put(8'hBB); gap(20);
`ifdef RX_CMD_TIMEOUT_EN
        check("timeout_err", err_cnt, 1);
        check("timeout_idle", busy, 0);
        put(8'hBB);
`else
        check("wait_no_err", err_cnt, 0);
        check("wait_busy", busy, 1);
`endif
        put(8'h03); gap(3);
        check("after_wait_rd", rd_q.size() == 1 ? rd_q[0] : -1, 3);

        clr_logs();
        put(8'hAA); put(8'h03); gap(0);
        rx_data_valid = 1'b0;
        rst_n = 1'b0; step();
        check("reset_mid_busy", busy, 0);
        rst_n = 1'b1; gap(3);
        check("reset_mid_no_wr", wr_q.size(), 0);

        for (int i = 0; i < 3000; i++) begin
            if (e_left == 0 && $urandom_range(0, 39) == 0) begin
                e_left = $urandom_range(1, 3);
                esel = 1'($urandom_range(0, 1));
            end
            rx_par_err = (e_left > 0) && esel;
            rx_frm_err = (e_left > 0) && !esel;
            if (e_left > 0) e_left--;
            rx_data_valid = $urandom_range(0, 2) != 0;
            rx_p_data = rnd_byte();
            if ($urandom_range(0, 299) == 0) begin
                rx_data_valid = 1'b0;
                repeat (20) step();
            end
            step();
        end
        rx_par_err = 1'b0;
        rx_frm_err = 1'b0;
        gap(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
